arcade_input_mapper: RTL and testbench
======================================

Name: arcade_input_mapper

Overview:
- Parametrised player-input front end for arcade cores; sits between hps_io (ps2_key, joystick_N) and the game core.
- Merges PS/2 keyboard events and per-player joysticks into the core's active-low control buses for N players and M fire buttons.
- Adds fixed-length coin pulses, per-button autofire, and a latched pause toggle.

Parameters:
NUM_PLAYERS, 2, number of players/joystick channels (1..4)
NUM_BUTTONS, 3, fire buttons per player (1..6); button k = joystick bit 4+k
START_BIT, 8, joystick bit index for that player's start
COIN_BIT, 9, joystick bit index for that player's coin
PAUSE_BIT, 10, joystick bit index for pause (any player)
COIN_PULSE_CYCLES, 4915200, coin output width in clocks (100 ms at 49.152 MHz)
AF_HALF_CYCLES, 1638400, autofire half-period in clocks (15 Hz)
KBD_PLAYER_MASK, 1, bitmask of players that receive keyboard directions/buttons

Ports:
clk_49m  in  1  core clock
reset  in  1  asynchronous, active-low reset
ps2_key  in  11  hps_io key event: [10] toggle, [9] pressed, [7:0] scancode
joystick  in  16*NUM_PLAYERS  packed joysticks, player p at [16p+15:16p], active-high
autofire_en  in  NUM_PLAYERS*NUM_BUTTONS  per-button autofire enable
joystick_n  out  4*NUM_PLAYERS  {right,left,down,up} per player, active-low
buttons_n  out  NUM_PLAYERS*NUM_BUTTONS  fire buttons, active-low
start_n  out  NUM_PLAYERS  start buttons, active-low
coin_n  out  NUM_PLAYERS  coin pulses, active-low
service_n  out  1  service switch, active-low
pause  out  1  pause toggle state, active-high

Behaviour:
- Reset: all *_n outputs 1, pause 0, all key latches 0, counters 0, af_phase 1, armed 0.
- Key events: armed=0 on first cycle after reset → copy ps2_key[10] into old_tog, set armed (no decode). Thereafter event when ps2_key[10]!=old_tog; old_tog updates every cycle. Decode on [7:0] only (bit 8 ignored): 16h start1, 1Eh start2, 2Eh coin1, 36h coin2, 46h service, 4Dh pause, 75h up, 72h down, 6Bh left, 74h right, 14h btn0, 11h btn1, 29h btn2; key latch <= ps2_key[9]. Unlisted codes, or buttons ≥NUM_BUTTONS, ignored.
- Merge (registered, 1-cycle latency): dir/button raw = joystick bit | (key latch & KBD_PLAYER_MASK[p]). Start/coin for player 0/1 also OR keyboard start/coin 1/2. Pause raw = key | OR of all joysticks' PAUSE_BIT.
- Autofire: free-running counter 0..AF_HALF_CYCLES-1; af_phase toggles at wrap. buttons_n = ~(raw & (autofire_en ? af_phase : 1)).
- Coin FSM per player: IDLE → (raw rising edge) PULSE, counter loaded; coin_n=0 for exactly COIN_PULSE_CYCLES clocks → WAIT_REL; WAIT_REL → IDLE when raw=0. Edges during PULSE/WAIT_REL ignored; holding coin gives one pulse only.
- Pause: toggles on raw rising edge; held input toggles once.
- Simultaneous key event and joystick change: both take effect same cycle (OR).
- Reset deasserted mid-pulse/mid-hold: all FSMs to IDLE, no output glitch low on reset.

Decomposition:
- Package arcade_input_pkg: scancode constants, joystick bit-index defaults, coin FSM state enum.
- Sub-module coin_pulser (one instance per player): edge detect + counter + 3-state FSM; reused for pause toggle edge detect is not required.

Test Plan:
- Reset with ps2_key[10]=1 then release → no event decoded; all *_n=1, pause=0.
- Toggle ps2_key[10], [9]=1, code 75h → joystick_n[0]=0 (P1 up) after 1 clk; P2 unaffected with KBD_PLAYER_MASK=1; release event → 1.
- joystick[16+COIN_BIT] held 3× COIN_PULSE_CYCLES → coin_n[1]=0 for exactly COIN_PULSE_CYCLES clocks, one pulse; release and re-press → second pulse.
- autofire_en[0]=1, joystick[4] held (AF_HALF_CYCLES=4 in bench) → buttons_n[0] alternates 4 low/4 high; autofire_en=0 → steady 0.
- Key 4Dh press, release, press → pause 0→1→1→0 per edge; simultaneous joystick PAUSE_BIT with key press → single toggle.
- Assert reset during coin pulse → coin_n=1 immediately; after release coin still held → no pulse until released and re-pressed.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// -----------------------------------------------------------------------------
// arcade_input_pkg
// Shared definitions for the arcade input front end. It holds:
//   - PS/2 set-2 scancodes that the mapper decodes
//   - default joystick bit positions (hps_io layout, active-high)
//   - the keyboard key-latch struct
//   - the coin pulser state encoding
//   - a helper that selects a keyboard fire button by index
// -----------------------------------------------------------------------------
package arcade_input_pkg;

  // Joystick word layout: bits 0..3 are directions, fire button k is bit 4+k.
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_BTN0  = 4;

  localparam int DEF_START_BIT = 8;
  localparam int DEF_COIN_BIT  = 9;
  localparam int DEF_PAUSE_BIT = 10;

  // Keyboard has three fire keys; more buttons are joystick-only.
  localparam int KBD_BUTTONS = 3;

  // PS/2 set-2 scancodes. The extended flag (ps2_key[8]) is not decoded, so
  // cursor keys and their keypad twins map to the same direction.
  localparam logic [7:0] SC_START1  = 8'h16;
  localparam logic [7:0] SC_START2  = 8'h1E;
  localparam logic [7:0] SC_COIN1   = 8'h2E;
  localparam logic [7:0] SC_COIN2   = 8'h36;
  localparam logic [7:0] SC_SERVICE = 8'h46;
  localparam logic [7:0] SC_PAUSE   = 8'h4D;
  localparam logic [7:0] SC_UP      = 8'h75;
  localparam logic [7:0] SC_DOWN    = 8'h72;
  localparam logic [7:0] SC_LEFT    = 8'h6B;
  localparam logic [7:0] SC_RIGHT   = 8'h74;
  localparam logic [7:0] SC_BTN0    = 8'h14;
  localparam logic [7:0] SC_BTN1    = 8'h11;
  localparam logic [7:0] SC_BTN2    = 8'h29;

  // One bit per decoded key, 1 = currently held.
  typedef struct packed {
    logic                   start1;
    logic                   start2;
    logic                   coin1;
    logic                   coin2;
    logic                   service;
    logic                   pause;
    logic                   up;
    logic                   down;
    logic                   left;
    logic                   right;
    logic [KBD_BUTTONS-1:0] btn;
  } key_latch_t;

  typedef enum logic [1:0] {
    COIN_IDLE     = 2'd0,
    COIN_PULSE    = 2'd1,
    COIN_WAIT_REL = 2'd2
  } coin_state_e;

  // Keyboard fire key for button index idx; indices without a key read 0.
  function automatic logic kbd_button(input key_latch_t keys, input int idx);
    logic res;
    case (idx)
      0:       res = keys.btn[0];
      1:       res = keys.btn[1];
      2:       res = keys.btn[2];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/coin_pulser.sv
// -----------------------------------------------------------------------------
// coin_pulser
// Turns a level coin request into a single fixed-width pulse.
//   IDLE     : waits for a rising edge of i_raw, then loads the counter
//   PULSE    : pulse active for exactly PULSE_CYCLES clocks
//   WAIT_REL : waits for i_raw to drop; edges before that are ignored
// Ports:
//   i_clk    core clock
//   i_rst_n  asynchronous active-low reset
//   i_raw    coin request level (active-high, combinational merge)
//   o_state  current FSM state; the pulse is (o_state == COIN_PULSE)
// The state is registered, so the pulse starts one clock after i_raw rises.
// -----------------------------------------------------------------------------
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int PULSE_CYCLES = 4915200
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_raw,
  output coin_state_e o_state
);

  localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES - 1);

  coin_state_e   r_state;
  coin_state_e   w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_prev;

  // r_prev resets to 1 so a coin still held when reset releases is not seen
  // as a fresh insertion; it must be released and pressed again.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= COIN_IDLE;
      r_cnt   <= '0;
      r_prev  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_prev  <= i_raw;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      COIN_IDLE: begin
        if (i_raw && !r_prev) begin
          w_state_next = COIN_PULSE;
          w_cnt_next   = CNT_LOAD;
        end
      end
      COIN_PULSE: begin
        if (r_cnt == '0) begin
          w_state_next = COIN_WAIT_REL;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      COIN_WAIT_REL: begin
        if (!i_raw) begin
          w_state_next = COIN_IDLE;
        end
      end
      default: begin
        w_state_next = COIN_IDLE;
      end
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/arcade_input_mapper.sv
// -----------------------------------------------------------------------------
// arcade_input_mapper
// Player-input front end between hps_io and an arcade core. It merges PS/2
// key events with per-player joysticks into active-low control buses. It adds
// fixed-width coin pulses, per-button autofire and a latched pause toggle.
// Ports:
//   clk_49m      core clock
//   reset        asynchronous active-low reset
//   ps2_key      [10] event toggle, [9] pressed, [8] extended (unused), [7:0] code
//   joystick     player p at [16p+15:16p], active-high
//   autofire_en  per-button autofire enable, player-major
//   joystick_n   {right,left,down,up} per player, active-low
//   buttons_n    fire buttons, player-major, active-low
//   start_n      start per player, active-low
//   coin_n       coin pulse per player, active-low
//   service_n    service switch, active-low
//   pause        pause toggle state, active-high
// Key event protocol: hps_io flips ps2_key[10] once per key event, and the
// other bits are valid in that cycle. There is no back-pressure. An event is
// any cycle where ps2_key[10] differs from its value on the previous clock.
// On the first clock after reset the toggle is only sampled, because its
// reset-time value carries no event.
// Every output except autofire gating is registered, so inputs and key
// events reach the outputs one clock later.
// -----------------------------------------------------------------------------
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int         NUM_PLAYERS       = 2,
  parameter int         NUM_BUTTONS       = 3,
  parameter int         START_BIT         = DEF_START_BIT,
  parameter int         COIN_BIT          = DEF_COIN_BIT,
  parameter int         PAUSE_BIT         = DEF_PAUSE_BIT,
  parameter int         COIN_PULSE_CYCLES = 4915200,
  parameter int         AF_HALF_CYCLES    = 1638400,
  parameter logic [3:0] KBD_PLAYER_MASK   = 4'b0001
) (
  input  logic                               clk_49m,
  input  logic                               reset,
  input  logic [10:0]                        ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]          joystick,
  input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0] autofire_en,
  output logic [4*NUM_PLAYERS-1:0]           joystick_n,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] buttons_n,
  output logic [NUM_PLAYERS-1:0]             start_n,
  output logic [NUM_PLAYERS-1:0]             coin_n,
  output logic                               service_n,
  output logic                               pause
);

  localparam int NBT = NUM_PLAYERS * NUM_BUTTONS;
  localparam int AW  = (AF_HALF_CYCLES > 1) ? $clog2(AF_HALF_CYCLES) : 1;
  localparam logic [AW-1:0] AF_LAST = AW'(AF_HALF_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Key event detection and key latches
  // ---------------------------------------------------------------------------
  logic       r_armed;
  logic       r_old_tog;
  key_latch_t r_keys;
  key_latch_t w_keys_next;
  logic       w_key_event;

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      r_armed   <= 1'b0;
      r_old_tog <= 1'b0;
      r_keys    <= '0;
    end else begin
      r_armed   <= 1'b1;
      r_old_tog <= ps2_key[10];
      r_keys    <= w_keys_next;
    end
  end

  assign w_key_event = r_armed && (ps2_key[10] != r_old_tog);

  always_comb begin
    w_keys_next = r_keys;
    if (w_key_event) begin
      case (ps2_key[7:0])
        SC_START1:  w_keys_next.start1  = ps2_key[9];
        SC_START2:  w_keys_next.start2  = ps2_key[9];
        SC_COIN1:   w_keys_next.coin1   = ps2_key[9];
        SC_COIN2:   w_keys_next.coin2   = ps2_key[9];
        SC_SERVICE: w_keys_next.service = ps2_key[9];
        SC_PAUSE:   w_keys_next.pause   = ps2_key[9];
        SC_UP:      w_keys_next.up      = ps2_key[9];
        SC_DOWN:    w_keys_next.down    = ps2_key[9];
        SC_LEFT:    w_keys_next.left    = ps2_key[9];
        SC_RIGHT:   w_keys_next.right   = ps2_key[9];
        SC_BTN0:    w_keys_next.btn[0]  = ps2_key[9];
        SC_BTN1:    w_keys_next.btn[1]  = ps2_key[9];
        SC_BTN2:    w_keys_next.btn[2]  = ps2_key[9];
        default:    w_keys_next = r_keys;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Merge. The next-cycle key latch value is used, so a key event and a
  // joystick change in the same cycle reach the outputs together.
  // ---------------------------------------------------------------------------
  logic [4*NUM_PLAYERS-1:0] w_dir_raw;
  logic [NBT-1:0]           w_btn_raw;
  logic [NUM_PLAYERS-1:0]   w_start_raw;
  logic [NUM_PLAYERS-1:0]   w_coin_raw;
  logic                     w_pause_raw;
  logic                     w_service_raw;

  always_comb begin
    w_dir_raw     = '0;
    w_btn_raw     = '0;
    w_start_raw   = '0;
    w_coin_raw    = '0;
    w_pause_raw   = w_keys_next.pause;
    w_service_raw = w_keys_next.service;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_dir_raw[4*p+0] = joystick[16*p+JOY_UP]    | (w_keys_next.up    & KBD_PLAYER_MASK[p]);
      w_dir_raw[4*p+1] = joystick[16*p+JOY_DOWN]  | (w_keys_next.down  & KBD_PLAYER_MASK[p]);
      w_dir_raw[4*p+2] = joystick[16*p+JOY_LEFT]  | (w_keys_next.left  & KBD_PLAYER_MASK[p]);
      w_dir_raw[4*p+3] = joystick[16*p+JOY_RIGHT] | (w_keys_next.right & KBD_PLAYER_MASK[p]);
      for (int k = 0; k < NUM_BUTTONS; k++) begin
        w_btn_raw[NUM_BUTTONS*p+k] = joystick[16*p+JOY_BTN0+k]
                                   | (kbd_button(w_keys_next, k) & KBD_PLAYER_MASK[p]);
      end
      // Keyboard start/coin keys belong to players 1 and 2 regardless of mask.
      w_start_raw[p] = joystick[16*p+START_BIT]
                     | ((p == 0) & w_keys_next.start1)
                     | ((p == 1) & w_keys_next.start2);
      w_coin_raw[p]  = joystick[16*p+COIN_BIT]
                     | ((p == 0) & w_keys_next.coin1)
                     | ((p == 1) & w_keys_next.coin2);
      w_pause_raw    = w_pause_raw | joystick[16*p+PAUSE_BIT];
    end
  end

  // ---------------------------------------------------------------------------
  // Registered levels, pause toggle and autofire timebase
  // ---------------------------------------------------------------------------
  logic [4*NUM_PLAYERS-1:0] r_dir_raw;
  logic [NBT-1:0]           r_btn_raw;
  logic [NUM_PLAYERS-1:0]   r_start_raw;
  logic                     r_service_raw;
  logic                     r_pause;
  logic                     r_pause_prev;
  logic [AW-1:0]            r_af_cnt;
  logic                     r_af_phase;

  // r_pause_prev resets to 1 so pause held across reset does not toggle.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      r_dir_raw     <= '0;
      r_btn_raw     <= '0;
      r_start_raw   <= '0;
      r_service_raw <= 1'b0;
      r_pause       <= 1'b0;
      r_pause_prev  <= 1'b1;
    end else begin
      r_dir_raw     <= w_dir_raw;
      r_btn_raw     <= w_btn_raw;
      r_start_raw   <= w_start_raw;
      r_service_raw <= w_service_raw;
      r_pause_prev  <= w_pause_raw;
      if (w_pause_raw && !r_pause_prev) begin
        r_pause <= ~r_pause;
      end
    end
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      r_af_cnt   <= '0;
      r_af_phase <= 1'b1;
    end else if (r_af_cnt == AF_LAST) begin
      r_af_cnt   <= '0;
      r_af_phase <= ~r_af_phase;
    end else begin
      r_af_cnt   <= r_af_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Coin pulsers
  // ---------------------------------------------------------------------------
  coin_state_e w_coin_state [NUM_PLAYERS];

  for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_coin
    coin_pulser #(
      .PULSE_CYCLES (COIN_PULSE_CYCLES)
    ) u_coin_pulser (
      .i_clk   (clk_49m),
      .i_rst_n (reset),
      .i_raw   (w_coin_raw[gp]),
      .o_state (w_coin_state[gp])
    );
    assign coin_n[gp] = (w_coin_state[gp] != COIN_PULSE);
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign joystick_n = ~r_dir_raw;
  // An autofire-enabled button is only passed during the high half-period.
  assign buttons_n  = ~(r_btn_raw & (~autofire_en | {NBT{r_af_phase}}));
  assign start_n    = ~r_start_raw;
  assign service_n  = ~r_service_raw;
  assign pause      = r_pause;

  // Extended-key flag and joystick bits beyond the mapped ones are unused.
  logic w_unused;
  assign w_unused = ^{ps2_key[8], joystick};

endmodule

// File: tb/tb_arcade_input_mapper.sv
// -----------------------------------------------------------------------------
// tb_arcade_input_mapper
// Bench for arcade_input_mapper with 2 players, 3 buttons, an 8-clock coin
// pulse and a 4-clock autofire half-period. Each tick pushes the expected
// output word for the coming clock edge, advances one clock, and then pops and
// compares at the falling edge. The expected word is built from model_*
// variables set by each test step.
// -----------------------------------------------------------------------------
module tb_arcade_input_mapper;

  localparam int NP     = 2;
  localparam int NB     = 3;
  localparam int COIN_N = 8;
  localparam int AF_H   = 4;
  localparam int W      = 20;

  // Clock / reset
  logic clk_49m = 1'b0;
  logic reset;
  always #5 clk_49m = ~clk_49m;

  // DUT signals
  logic [10:0]      ps2_key;
  logic [16*NP-1:0] joystick;
  logic [NP*NB-1:0] autofire_en;
  logic [4*NP-1:0]  joystick_n;
  logic [NP*NB-1:0] buttons_n;
  logic [NP-1:0]    start_n;
  logic [NP-1:0]    coin_n;
  logic             service_n;
  logic             pause;

  arcade_input_mapper #(
    .NUM_PLAYERS       (NP),
    .NUM_BUTTONS       (NB),
    .START_BIT         (8),
    .COIN_BIT          (9),
    .PAUSE_BIT         (10),
    .COIN_PULSE_CYCLES (COIN_N),
    .AF_HALF_CYCLES    (AF_H),
    .KBD_PLAYER_MASK   (4'b0001)
  ) dut (
    .clk_49m     (clk_49m),
    .reset       (reset),
    .ps2_key     (ps2_key),
    .joystick    (joystick),
    .autofire_en (autofire_en),
    .joystick_n  (joystick_n),
    .buttons_n   (buttons_n),
    .start_n     (start_n),
    .coin_n      (coin_n),
    .service_n   (service_n),
    .pause       (pause)
  );

  // Clock edges since reset release; sets the expected autofire phase.
  int cyc;
  always @(posedge clk_49m or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Expected output state
  logic [4*NP-1:0]  model_dir_n;
  logic [NP*NB-1:0] model_btn;
  logic [NP-1:0]    model_start_n;
  logic [NP-1:0]    model_coin_n;
  logic             model_service_n;
  logic             model_pause;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int af_low   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_idle();
    model_dir_n     = '1;
    model_btn       = '0;
    model_start_n   = '1;
    model_coin_n    = '1;
    model_service_n = 1'b1;
    model_pause     = 1'b0;
  endtask

  // Autofire phase after edge n: high for edges 0..AF_H-1, then alternating.
  function automatic logic [W-1:0] exp_vec(input int n);
    logic             ph;
    logic [NP*NB-1:0] gate;
    ph   = ((n / AF_H) % 2) == 0;
    gate = ~autofire_en | {(NP*NB){ph}};
    return {model_pause, model_service_n, model_coin_n, model_start_n,
            ~(model_btn & gate), model_dir_n};
  endfunction

  function automatic logic [W-1:0] obs();
    return {pause, service_n, coin_n, start_n, buttons_n, joystick_n};
  endfunction

  task automatic tick(input string tag);
    exp_q.push_back(exp_vec(cyc + 1));
    @(posedge clk_49m);
    @(negedge clk_49m);
    check(tag, obs(), exp_q.pop_front());
  endtask

  // Driver: one key event = flip the toggle bit with new press/code fields.
  task automatic key_event(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  initial begin
    reset       = 1'b0;
    ps2_key     = {1'b1, 1'b1, 1'b1, 8'h75};
    joystick    = '0;
    autofire_en = '0;
    model_idle();

    // Reset with the toggle high, then release: nothing may be decoded.
    @(negedge clk_49m);
    tick("reset_state");
    tick("reset_state");
    reset = 1'b1;
    repeat (3) tick("arm_no_event");

    // Keyboard up (extended code) for player 1 only
    key_event(1'b1, 1'b1, 8'h75); model_dir_n[0] = 1'b0; tick("kbd_up_press");
    tick("kbd_up_hold");
    key_event(1'b0, 1'b1, 8'h75); model_dir_n[0] = 1'b1; tick("kbd_up_release");

    // Keyboard buttons, start2, service, unlisted code
    key_event(1'b1, 1'b0, 8'h14); model_btn[0] = 1'b1; tick("kbd_btn0");
    key_event(1'b1, 1'b0, 8'h29); model_btn[2] = 1'b1; tick("kbd_btn2");
    key_event(1'b0, 1'b0, 8'h14); model_btn[0] = 1'b0; tick("kbd_btn0_rel");
    key_event(1'b0, 1'b0, 8'h29); model_btn[2] = 1'b0; tick("kbd_btn2_rel");
    key_event(1'b1, 1'b0, 8'h1E); model_start_n[1] = 1'b0; tick("kbd_start2");
    key_event(1'b0, 1'b0, 8'h1E); model_start_n[1] = 1'b1; tick("kbd_start2_rel");
    key_event(1'b1, 1'b0, 8'h46); model_service_n = 1'b0; tick("kbd_service");
    key_event(1'b0, 1'b0, 8'h46); model_service_n = 1'b1; tick("kbd_service_rel");
    key_event(1'b1, 1'b0, 8'h1C); tick("kbd_unlisted");
    key_event(1'b0, 1'b0, 8'h1C); tick("kbd_unlisted_rel");

    // Key event and joystick change in the same cycle
    key_event(1'b1, 1'b1, 8'h6B); joystick[16+1] = 1'b1;
    model_dir_n[2] = 1'b0; model_dir_n[6] = 1'b0; tick("simul_key_joy");
    key_event(1'b0, 1'b1, 8'h6B); joystick[16+1] = 1'b0;
    model_dir_n[2] = 1'b1; model_dir_n[6] = 1'b1; tick("simul_key_joy_rel");

    // Joystick directions and start
    joystick[0] = 1'b1; joystick[16+3] = 1'b1; joystick[8] = 1'b1;
    model_dir_n[3] = 1'b0; model_dir_n[4] = 1'b0; model_start_n[0] = 1'b0;
    tick("joy_dirs_start");
    joystick = '0; model_dir_n = '1; model_start_n = '1; tick("joy_release");

    // Player 2 coin held for three pulse lengths: exactly one pulse
    joystick[16+9] = 1'b1;
    model_coin_n[1] = 1'b0; repeat (COIN_N) tick("coin_pulse");
    model_coin_n[1] = 1'b1; repeat (2*COIN_N) tick("coin_held");
    joystick[16+9] = 1'b0; repeat (2) tick("coin_released");
    joystick[16+9] = 1'b1;
    model_coin_n[1] = 1'b0; repeat (COIN_N) tick("coin_repulse");
    model_coin_n[1] = 1'b1; tick("coin_repulse_end");
    joystick[16+9] = 1'b0; tick("coin_idle");

    // Autofire on P1 button 0: half the samples low, then steady with it off
    autofire_en[0] = 1'b1; joystick[4] = 1'b1; model_btn[0] = 1'b1;
    for (int i = 0; i < 4*AF_H; i++) begin
      tick("af_on");
      if (buttons_n[0] == 1'b0) af_low++;
    end
    check("af_low_count", af_low, 2*AF_H);
    autofire_en[0] = 1'b0; repeat (2*AF_H) tick("af_off");
    joystick[4] = 1'b0; model_btn[0] = 1'b0; tick("af_release");

    // Pause toggle on rising edges only
    key_event(1'b1, 1'b0, 8'h4D); model_pause = 1'b1; tick("pause_press1");
    tick("pause_hold1");
    key_event(1'b0, 1'b0, 8'h4D); tick("pause_rel1");
    key_event(1'b1, 1'b0, 8'h4D); model_pause = 1'b0; tick("pause_press2");
    key_event(1'b0, 1'b0, 8'h4D); tick("pause_rel2");
    key_event(1'b1, 1'b0, 8'h4D); joystick[10] = 1'b1; model_pause = 1'b1;
    tick("pause_simul");
    tick("pause_simul_hold");
    key_event(1'b0, 1'b0, 8'h4D); tick("pause_key_rel_joy_held");
    joystick[10] = 1'b0; tick("pause_all_rel");
    joystick[16+10] = 1'b1; model_pause = 1'b0; tick("pause_joy2");
    joystick[16+10] = 1'b0; tick("pause_joy2_rel");

    // Reset in the middle of a P1 coin pulse
    joystick[9] = 1'b1;
    model_coin_n[0] = 1'b0; repeat (3) tick("coin0_pulse");
    #2 reset = 1'b0;
    model_idle();
    exp_q.push_back(exp_vec(0));
    #1 check("reset_mid_pulse", obs(), exp_q.pop_front());
    tick("reset_mid_hold");
    reset = 1'b1;
    repeat (2*COIN_N) tick("coin_held_after_reset");
    joystick[9] = 1'b0; repeat (2) tick("coin0_released");
    joystick[9] = 1'b1;
    model_coin_n[0] = 1'b0; repeat (COIN_N) tick("coin0_after_reset");
    model_coin_n[0] = 1'b1; tick("coin0_after_reset_end");
    joystick[9] = 1'b0; tick("coin0_idle");

    check("queue_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
